cvxif_copro_scheduler: RTL and testbench

In-order issue/commit/execute scheduler for the CV-X-IF example coprocessor. It sits between the core's CV-X-IF issue, commit and result channels and a single-issue coprocessor execution unit (EXU). It decodes and accepts the three custom instruction classes (custom1, custom2, mad) and holds them in a small circular in-flight table until the core commits or kills them. It then dispatches committed operations to the EXU one at a time and returns results to the core in program order.

---
 rtl/cvxif_copro_scheduler.sv | 202 ++++++++++++++++++++
 tb/tb_cvxif_copro_scheduler.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cvxif_copro_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : cvxif_copro_scheduler
// Description : In-order issue/commit/execute scheduler between the CV-X-IF
//               issue/commit/result channels and a single-issue coprocessor
//               execution unit. Holds accepted ops in a circular table,
//               dispatches committed ops one at a time and returns results
//               from the head in program order.
// Revision    : 1.0 - initial release
// ============================================================================
module cvxif_copro_scheduler #(
  parameter int NrEntries = 4,
  parameter int IdWidth   = 3,
  parameter int XLEN      = 32
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               issue_valid_i,
  output logic               issue_ready_o,
  input  logic [31:0]        issue_instr_i,
  input  logic [IdWidth-1:0] issue_id_i,
  input  logic [XLEN-1:0]    issue_rs0_i,
  input  logic [XLEN-1:0]    issue_rs1_i,
  input  logic [XLEN-1:0]    issue_rs2_i,
  output logic               issue_accept_o,
  output logic               issue_writeback_o,
  input  logic               commit_valid_i,
  input  logic [IdWidth-1:0] commit_id_i,
  input  logic               commit_kill_i,
  output logic               exu_valid_o,
  input  logic               exu_ready_i,
  output logic [1:0]         exu_op_o,
  output logic [XLEN-1:0]    exu_rs0_o,
  output logic [XLEN-1:0]    exu_rs1_o,
  output logic [XLEN-1:0]    exu_rs2_o,
  input  logic               exu_done_i,
  input  logic [XLEN-1:0]    exu_result_i,
  output logic               result_valid_o,
  input  logic               result_ready_i,
  output logic [IdWidth-1:0] result_id_o,
  output logic [XLEN-1:0]    result_data_o,
  output logic [4:0]         result_rd_o,
  output logic               result_we_o
);

  localparam int PtrW = (NrEntries > 1) ? $clog2(NrEntries) : 1;
  localparam int CntW = PtrW + 1;
  localparam logic [CntW-1:0] c_full = CntW'(NrEntries);

  localparam logic [1:0] c_op_custom1 = 2'd0;
  localparam logic [1:0] c_op_custom2 = 2'd1;
  localparam logic [1:0] c_op_mad     = 2'd2;

  typedef enum logic [2:0] {
    ST_FREE      = 3'd0,
    ST_ISSUED    = 3'd1,
    ST_COMMITTED = 3'd2,
    ST_EXEC      = 3'd3,
    ST_DONE      = 3'd4,
    ST_KILLED    = 3'd5
  } entry_state_e;

  entry_state_e        r_state [NrEntries];
  logic [IdWidth-1:0]  r_id    [NrEntries];
  logic [1:0]          r_op    [NrEntries];
  logic [4:0]          r_rd    [NrEntries];
  logic                r_wb    [NrEntries];
  logic [XLEN-1:0]     r_rs0   [NrEntries];
  logic [XLEN-1:0]     r_rs1   [NrEntries];
  logic [XLEN-1:0]     r_rs2   [NrEntries];
  logic [XLEN-1:0]     r_data  [NrEntries];

  logic [PtrW-1:0] r_head;
  logic [PtrW-1:0] r_tail;
  logic [PtrW-1:0] r_disp;
  logic [PtrW-1:0] r_exec_idx;
  logic            r_exec_busy;
  logic [CntW-1:0] r_count;

  logic       w_accept;
  logic       w_wb;
  logic [1:0] w_op;
  logic       w_alloc;
  logic       w_exu_valid;
  logic       w_exu_fire;
  logic       w_skip;
  logic       w_done;
  logic       w_res_valid;
  logic       w_free;
  logic       w_unused;

  // Instruction decode; first matching class wins
  always_comb begin
    w_accept = 1'b0;
    w_wb     = 1'b0;
    w_op     = c_op_custom1;
    if (issue_instr_i[6:0] == 7'b0101011) begin
      w_accept = 1'b1;
    end else if (issue_instr_i[6:0] == 7'b1011011) begin
      w_accept = 1'b1;
      w_wb     = 1'b1;
      w_op     = c_op_custom2;
    end else if (issue_instr_i[31:25] == 7'b0000011 && issue_instr_i[6:0] == 7'b0110011) begin
      w_accept = 1'b1;
      w_wb     = 1'b1;
      w_op     = c_op_mad;
    end
  end

  // Only opcode, funct7 and rd are meaningful to this scheduler
  assign w_unused = ^issue_instr_i[24:12];

  assign issue_ready_o     = (r_count < c_full);
  assign issue_accept_o    = issue_valid_i & w_accept;
  assign issue_writeback_o = issue_valid_i & w_wb;
  assign w_alloc           = issue_valid_i & issue_ready_o & w_accept;

  // Dispatch side: one outstanding EXU op, killed entries skipped in place
  assign w_exu_valid = ~r_exec_busy & (r_state[r_disp] == ST_COMMITTED);
  assign w_exu_fire  = w_exu_valid & exu_ready_i;
  assign w_skip      = (r_state[r_disp] == ST_KILLED);
  assign w_done      = exu_done_i & r_exec_busy;

  assign exu_valid_o = w_exu_valid;
  assign exu_op_o    = w_exu_valid ? r_op[r_disp]  : 2'd0;
  assign exu_rs0_o   = w_exu_valid ? r_rs0[r_disp] : '0;
  assign exu_rs1_o   = w_exu_valid ? r_rs1[r_disp] : '0;
  assign exu_rs2_o   = w_exu_valid ? r_rs2[r_disp] : '0;

  // Result side: head only; killed heads retire silently
  assign w_res_valid = (r_state[r_head] == ST_DONE);
  assign w_free      = (w_res_valid & result_ready_i) | (r_state[r_head] == ST_KILLED);

  assign result_valid_o = w_res_valid;
  assign result_id_o    = w_res_valid ? r_id[r_head]   : '0;
  assign result_data_o  = w_res_valid ? r_data[r_head] : '0;
  assign result_rd_o    = w_res_valid ? r_rd[r_head]   : 5'd0;
  assign result_we_o    = w_res_valid & r_wb[r_head];

  // Table, pointers and occupancy count
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < NrEntries; i++) begin
        r_state[i] <= ST_FREE;
        r_id[i]    <= '0;
        r_op[i]    <= 2'd0;
        r_rd[i]    <= 5'd0;
        r_wb[i]    <= 1'b0;
        r_rs0[i]   <= '0;
        r_rs1[i]   <= '0;
        r_rs2[i]   <= '0;
        r_data[i]  <= '0;
      end
      r_head      <= '0;
      r_tail      <= '0;
      r_disp      <= '0;
      r_exec_idx  <= '0;
      r_exec_busy <= 1'b0;
      r_count     <= '0;
    end else begin
      if (w_alloc) begin
        r_state[r_tail] <= ST_ISSUED;
        r_id[r_tail]    <= issue_id_i;
        r_op[r_tail]    <= w_op;
        r_rd[r_tail]    <= issue_instr_i[11:7];
        r_wb[r_tail]    <= w_wb;
        r_rs0[r_tail]   <= issue_rs0_i;
        r_rs1[r_tail]   <= issue_rs1_i;
        r_rs2[r_tail]   <= issue_rs2_i;
        r_tail          <= r_tail + PtrW'(1);
      end
      if (commit_valid_i) begin
        for (int i = 0; i < NrEntries; i++) begin
          if (r_state[i] == ST_ISSUED && r_id[i] == commit_id_i) begin
            r_state[i] <= commit_kill_i ? ST_KILLED : ST_COMMITTED;
          end
        end
      end
      if (w_exu_fire) begin
        r_state[r_disp] <= ST_EXEC;
        r_exec_idx      <= r_disp;
        r_exec_busy     <= 1'b1;
        r_disp          <= r_disp + PtrW'(1);
      end else if (w_skip) begin
        r_disp <= r_disp + PtrW'(1);
      end
      // Non-writeback ops return zero data so the core can simply retire them
      if (w_done) begin
        r_state[r_exec_idx] <= ST_DONE;
        r_data[r_exec_idx]  <= r_wb[r_exec_idx] ? exu_result_i : '0;
        r_exec_busy         <= 1'b0;
      end
      if (w_free) begin
        r_state[r_head] <= ST_FREE;
        r_head          <= r_head + PtrW'(1);
      end
      r_count <= r_count + CntW'(w_alloc) - CntW'(w_free);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_cvxif_copro_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_cvxif_copro_scheduler
// Description : Directed self-checking bench for cvxif_copro_scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cvxif_copro_scheduler;

  localparam logic [31:0] c_c2_rd3  = 32'h0000_01DB; // custom2, rd=3
  localparam logic [31:0] c_c1_rd5  = 32'h0000_02AB; // custom1, rd=5
  localparam logic [31:0] c_mad_rd4 = 32'h0600_0233; // mad, rd=4
  localparam logic [31:0] c_add     = 32'h0000_0033; // plain ADD

  logic        clk = 1'b0;
  logic        rst_i;
  logic        issue_valid_i;
  logic        issue_ready_o;
  logic [31:0] issue_instr_i;
  logic [2:0]  issue_id_i;
  logic [31:0] issue_rs0_i, issue_rs1_i, issue_rs2_i;
  logic        issue_accept_o, issue_writeback_o;
  logic        commit_valid_i;
  logic [2:0]  commit_id_i;
  logic        commit_kill_i;
  logic        exu_valid_o, exu_ready_i;
  logic [1:0]  exu_op_o;
  logic [31:0] exu_rs0_o, exu_rs1_o, exu_rs2_o;
  logic        exu_done_i;
  logic [31:0] exu_result_i;
  logic        result_valid_o, result_ready_i;
  logic [2:0]  result_id_o;
  logic [31:0] result_data_o;
  logic [4:0]  result_rd_o;
  logic        result_we_o;

  int checks = 0;
  int errors = 0;

  cvxif_copro_scheduler dut (
    .clk_i(clk), .rst_i(rst_i),
    .issue_valid_i(issue_valid_i), .issue_ready_o(issue_ready_o),
    .issue_instr_i(issue_instr_i), .issue_id_i(issue_id_i),
    .issue_rs0_i(issue_rs0_i), .issue_rs1_i(issue_rs1_i), .issue_rs2_i(issue_rs2_i),
    .issue_accept_o(issue_accept_o), .issue_writeback_o(issue_writeback_o),
    .commit_valid_i(commit_valid_i), .commit_id_i(commit_id_i), .commit_kill_i(commit_kill_i),
    .exu_valid_o(exu_valid_o), .exu_ready_i(exu_ready_i), .exu_op_o(exu_op_o),
    .exu_rs0_o(exu_rs0_o), .exu_rs1_o(exu_rs1_o), .exu_rs2_o(exu_rs2_o),
    .exu_done_i(exu_done_i), .exu_result_i(exu_result_i),
    .result_valid_o(result_valid_o), .result_ready_i(result_ready_i),
    .result_id_o(result_id_o), .result_data_o(result_data_o),
    .result_rd_o(result_rd_o), .result_we_o(result_we_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    issue_valid_i  = 1'b0; issue_instr_i = '0; issue_id_i = '0;
    issue_rs0_i    = '0;   issue_rs1_i   = '0; issue_rs2_i = '0;
    commit_valid_i = 1'b0; commit_id_i   = '0; commit_kill_i = 1'b0;
    exu_ready_i    = 1'b0; exu_done_i    = 1'b0; exu_result_i = '0;
    result_ready_i = 1'b0;
  endtask

  task automatic issue(input logic [31:0] instr, input logic [2:0] id,
                       input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
    issue_valid_i = 1'b1; issue_instr_i = instr; issue_id_i = id;
    issue_rs0_i = a; issue_rs1_i = b; issue_rs2_i = c;
  endtask

  task automatic commit(input logic [2:0] id, input logic kill);
    commit_valid_i = 1'b1; commit_id_i = id; commit_kill_i = kill;
  endtask

  initial begin
    clr();
    rst_i = 1'b1;
    tick(); tick();
    chk("rst_issue_ready", issue_ready_o, 1);
    chk("rst_exu_valid", exu_valid_o, 0);
    chk("rst_result_valid", result_valid_o, 0);
    chk("rst_result_data", result_data_o, 0);
    chk("rst_exu_rs0", exu_rs0_o, 0);
    rst_i = 1'b0;

    // ---- single custom2, minimum latency ----
    issue(c_c2_rd3, 3'd1, 32'd5, 32'd7, 32'd0);
    #1;
    chk("t1_accept", issue_accept_o, 1);
    chk("t1_wb", issue_writeback_o, 1);
    tick(); clr(); commit(3'd1, 1'b0);
    #1; chk("t1_no_exu_before_commit", exu_valid_o, 0);
    tick(); clr(); exu_ready_i = 1'b1;
    #1;
    chk("t1_exu_valid", exu_valid_o, 1);
    chk("t1_exu_op", exu_op_o, 1);
    chk("t1_exu_rs0", exu_rs0_o, 5);
    chk("t1_exu_rs1", exu_rs1_o, 7);
    tick(); clr(); exu_done_i = 1'b1; exu_result_i = 32'd12;
    #1;
    chk("t1_exu_busy", exu_valid_o, 0);
    chk("t1_result_early", result_valid_o, 0);
    tick(); clr(); result_ready_i = 1'b1;
    #1;
    chk("t1_result_valid", result_valid_o, 1);
    chk("t1_result_id", result_id_o, 1);
    chk("t1_result_data", result_data_o, 12);
    chk("t1_result_we", result_we_o, 1);
    chk("t1_result_rd", result_rd_o, 3);
    tick(); clr();
    #1; chk("t1_result_gone", result_valid_o, 0);

    // ---- non-coprocessor instruction ----
    issue(c_add, 3'd2, 32'd1, 32'd1, 32'd1);
    #1;
    chk("t2_accept", issue_accept_o, 0);
    chk("t2_wb", issue_writeback_o, 0);
    tick(); clr();
    #1;
    chk("t2_no_exu", exu_valid_o, 0);
    chk("t2_no_result", result_valid_o, 0);

    // ---- kill in the middle ----
    issue(c_mad_rd4, 3'd0, 32'd2, 32'd3, 32'd4); tick();
    issue(c_c2_rd3, 3'd1, 32'd8, 32'd9, 32'd0);  tick();
    issue(c_c1_rd5, 3'd2, 32'd6, 32'd0, 32'd0);
    #1; chk("t3_c1_wb", issue_writeback_o, 0);
    tick(); clr(); commit(3'd0, 1'b0);
    tick(); clr(); commit(3'd1, 1'b1); exu_ready_i = 1'b1;
    #1;
    chk("t3_exu0_valid", exu_valid_o, 1);
    chk("t3_exu0_op", exu_op_o, 2);
    chk("t3_exu0_rs2", exu_rs2_o, 4);
    tick(); clr(); commit(3'd2, 1'b0); exu_done_i = 1'b1; exu_result_i = 32'd10;
    #1; chk("t3_exu_single_outstanding", exu_valid_o, 0);
    tick(); clr(); result_ready_i = 1'b1; exu_ready_i = 1'b1;
    #1;
    chk("t3_res0_valid", result_valid_o, 1);
    chk("t3_res0_id", result_id_o, 0);
    chk("t3_res0_data", result_data_o, 10);
    chk("t3_res0_rd", result_rd_o, 4);
    chk("t3_exu2_valid", exu_valid_o, 1);
    chk("t3_exu2_op", exu_op_o, 0);
    chk("t3_exu2_rs0", exu_rs0_o, 6);
    tick(); clr(); exu_done_i = 1'b1; exu_result_i = 32'hDEAD; result_ready_i = 1'b1;
    #1; chk("t3_killed_silent", result_valid_o, 0);
    tick(); clr(); result_ready_i = 1'b1;
    #1;
    chk("t3_res2_valid", result_valid_o, 1);
    chk("t3_res2_id", result_id_o, 2);
    chk("t3_res2_we", result_we_o, 0);
    chk("t3_res2_data", result_data_o, 0);
    chk("t3_res2_rd", result_rd_o, 5);
    tick(); clr();
    #1; chk("t3_drained", result_valid_o, 0);

    // ---- fill the table ----
    for (int i = 3; i < 7; i++) begin
      issue(c_c2_rd3, 3'(i), 32'(i), 32'd0, 32'd0);
      #1; chk("t4_ready_before_full", issue_ready_o, 1);
      tick();
    end
    clr();
    #1; chk("t4_full", issue_ready_o, 0);
    commit(3'd3, 1'b0);
    tick(); clr(); exu_ready_i = 1'b1;
    #1;
    chk("t4_exu_valid", exu_valid_o, 1);
    chk("t4_exu_rs0", exu_rs0_o, 3);
    tick(); clr(); exu_done_i = 1'b1; exu_result_i = 32'h33;
    tick(); clr(); result_ready_i = 1'b1;
    #1;
    chk("t4_res_id", result_id_o, 3);
    chk("t4_res_data", result_data_o, 32'h33);
    chk("t4_still_full", issue_ready_o, 0);
    tick(); clr();
    #1; chk("t4_ready_after", issue_ready_o, 1);

    // ---- result back-pressure with two DONE entries ----
    commit(3'd4, 1'b0);
    tick(); clr(); commit(3'd5, 1'b0); exu_ready_i = 1'b1;
    #1; chk("t5_exu4_rs0", exu_rs0_o, 4);
    tick(); clr(); exu_done_i = 1'b1; exu_result_i = 32'h44; exu_ready_i = 1'b1;
    #1; chk("t5_exu_busy", exu_valid_o, 0);
    tick(); clr(); exu_ready_i = 1'b1;
    #1;
    chk("t5_exu5_valid", exu_valid_o, 1);
    chk("t5_exu5_rs0", exu_rs0_o, 5);
    tick(); clr(); exu_done_i = 1'b1; exu_result_i = 32'h55;
    tick(); clr();
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("t5_hold_valid", result_valid_o, 1);
      chk("t5_hold_id", result_id_o, 4);
      chk("t5_hold_data", result_data_o, 32'h44);
      tick();
    end
    result_ready_i = 1'b1;
    #1; chk("t5_first_id", result_id_o, 4);
    tick();
    #1;
    chk("t5_second_id", result_id_o, 5);
    chk("t5_second_data", result_data_o, 32'h55);
    tick(); clr();
    #1; chk("t5_head_issued", result_valid_o, 0);

    // ---- reset while an op executes with three entries live ----
    issue(c_c2_rd3, 3'd0, 32'd1, 32'd2, 32'd3); tick();
    issue(c_c2_rd3, 3'd1, 32'd1, 32'd2, 32'd3); tick();
    clr(); commit(3'd6, 1'b0);
    tick(); clr(); exu_ready_i = 1'b1;
    #1; chk("t6_exu6_valid", exu_valid_o, 1);
    tick(); clr(); rst_i = 1'b1;
    #1;
    chk("t6_rst_exu_valid", exu_valid_o, 0);
    chk("t6_rst_result_valid", result_valid_o, 0);
    chk("t6_rst_ready", issue_ready_o, 1);
    tick(); rst_i = 1'b0;
    #1;
    chk("t6_post_exu_rs0", exu_rs0_o, 0);
    chk("t6_post_result_id", result_id_o, 0);
    issue(c_c2_rd3, 3'd5, 32'd1, 32'd1, 32'd0);
    #1; chk("t6_accept", issue_accept_o, 1);
    tick(); clr(); commit(3'd5, 1'b0);
    tick(); clr(); exu_ready_i = 1'b1;
    #1; chk("t6_exu_valid", exu_valid_o, 1);
    tick(); clr(); exu_done_i = 1'b1; exu_result_i = 32'h99;
    tick(); clr(); result_ready_i = 1'b1;
    #1;
    chk("t6_res_id", result_id_o, 5);
    chk("t6_res_data", result_data_o, 32'h99);
    tick(); clr();
    #1; chk("t6_empty", result_valid_o, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
